regfile_mp: RTL and testbench

- Parametrised successor to the single-issue RISC-V integer register file.
- Adds configurable data width, register count and read-port count, and two write ports (ALU writeback and load writeback).
- Adds a per-register pending-write scoreboard for pipeline hazard detection.
- Adds a sequential bulk-clear engine used on core soft-restart.
- Sits between decode (reads, issue) and writeback (writes) in the pipeline.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_clr_fsm.sv | 62 ++++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port integer register file.
// Optional read forwarding is selected with the REGFILE_MP_BYPASS_EN macro.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]         xlen_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential bulk-clear engine: walks registers 1..NREG-1, one per cycle,
// emitting a zero-write strobe and address to the register array.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] FIRST = AW'(1);

  clr_state_e    state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_done   = 1'b0;
    clr_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          cnt_next   = FIRST;
        end
      end
      CLEAR: begin
        // Register 0 is never stored, so the walk starts at 1 and ends on the last entry.
        clr_we   = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          state_next = IDLE;
          clr_done   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clr_busy = (state_reg == CLEAR);
  assign clr_addr = cnt_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, pending-write scoreboard and
// bulk clear. Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  we0,
  input  logic [AW-1:0]         waddr0,
  input  logic [XLEN-1:0]       wdata0,
  input  logic                  we1,
  input  logic [AW-1:0]         waddr1,
  input  logic [XLEN-1:0]       wdata1,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_addr,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_reg, busy_next;
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            w0_en, w1_en;

  regfile_clr_fsm #(.NREG(NREG), .AW(AW)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign w0_en = we0 && !clr_busy && (waddr0 != '0);
  assign w1_en = we1 && !clr_busy && (waddr1 != '0);

  // Array has no reset; the clear engine owns the write path while active.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_addr] <= '0;
    end else begin
      if (w0_en && !(w1_en && (waddr1 == waddr0)))
        regs[waddr0] <= wdata0;
      if (w1_en)
        regs[waddr1] <= wdata1;
    end
  end

  always_comb begin
    busy_next = busy_reg;
    if (clr_busy) begin
      busy_next[clr_addr] = 1'b0;
    end else begin
      if (we0)      busy_next[waddr0]     = 1'b0;
      if (we1)      busy_next[waddr1]     = 1'b0;
      // A newly issued producer outranks a retiring write to the same register.
      if (issue_en) busy_next[issue_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = raddr[gi*AW +: AW];

    always_comb begin
      rd = regs[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (!clr_busy) begin
        if (we1 && (waddr1 == ra))      rd = wdata1;
        else if (we0 && (waddr0 == ra)) rd = wdata0;
      end
`endif
      if (ra == '0) rd = '0;
    end

    assign rdata[gi*XLEN +: XLEN] = rd;
    assign rbusy[gi]              = busy_reg[ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 32x32/2-port and a 16x64/4-port instance
// run in lock step against an array-based reference model.
module tb_regfile_mp;

  typedef struct {
    string       name;
    int          kind;   // 0 rdata, 1 rbusy, 2 clr_busy, 3 clr_done
    int          inst;
    int          port;
    logic [63:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst_n;
  logic we0 [2], we1 [2], iss [2], creq [2];
  logic [4:0]  wa0 [2], wa1 [2], ia [2];
  logic [63:0] wd0 [2], wd1 [2];
  logic [4:0]  ra [2][4];
  logic [63:0]  rdata_a;
  logic [255:0] rdata_b;
  logic [1:0]   rbusy_a;
  logic [3:0]   rbusy_b;
  logic cbusy [2], cdone [2];

  int checks = 0;
  int errors = 0;
  chk_t q[$];

  logic [63:0] m_regs  [2][32];
  bit          m_busy  [2][32];
  bit          m_known [2][32];
  bit          m_clr [2];
  int          m_idx [2];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREG(32), .NREAD(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .raddr({ra[0][1], ra[0][0]}), .rdata(rdata_a), .rbusy(rbusy_a),
    .we0(we0[0]), .waddr0(wa0[0]), .wdata0(wd0[0][31:0]),
    .we1(we1[0]), .waddr1(wa1[0]), .wdata1(wd1[0][31:0]),
    .issue_en(iss[0]), .issue_addr(ia[0]),
    .clr_req(creq[0]), .clr_busy(cbusy[0]), .clr_done(cdone[0])
  );

  regfile_mp #(.XLEN(64), .NREG(16), .NREAD(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .raddr({ra[1][3][3:0], ra[1][2][3:0], ra[1][1][3:0], ra[1][0][3:0]}),
    .rdata(rdata_b), .rbusy(rbusy_b),
    .we0(we0[1]), .waddr0(wa0[1][3:0]), .wdata0(wd0[1]),
    .we1(we1[1]), .waddr1(wa1[1][3:0]), .wdata1(wd1[1]),
    .issue_en(iss[1]), .issue_addr(ia[1][3:0]),
    .clr_req(creq[1]), .clr_busy(cbusy[1]), .clr_done(cdone[1])
  );

  function automatic int nreg_of(input int i);
    return (i == 1) ? 16 : 32;
  endfunction

  function automatic logic [63:0] dmask(input int i);
    return (i == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) m_busy[i][r] = 1'b0;
      m_clr[i] = 1'b0;
      m_idx[i] = 0;
    end
  endtask

  // Expected read value seen during the current cycle; k=0 means never written.
  task automatic exp_read(input int i, input int a, output logic [63:0] v, output bit k);
    int msk = nreg_of(i) - 1;
    v = m_regs[i][a];
    k = m_known[i][a];
`ifdef REGFILE_MP_BYPASS_EN
    if (!m_clr[i]) begin
      if (we1[i] && (int'(wa1[i]) & msk) == a) begin v = wd1[i] & dmask(i); k = 1; end
      else if (we0[i] && (int'(wa0[i]) & msk) == a) begin v = wd0[i] & dmask(i); k = 1; end
    end
`endif
    if (a == 0) begin v = '0; k = 1; end
  endtask

  task automatic model_update(input int i);
    int n   = nreg_of(i);
    int msk = n - 1;
    int a0  = int'(wa0[i]) & msk;
    int a1  = int'(wa1[i]) & msk;
    int ai  = int'(ia[i]) & msk;
    if (!rst_n) return;
    if (m_clr[i]) begin
      m_regs[i][m_idx[i]]  = '0;
      m_known[i][m_idx[i]] = 1'b1;
      m_busy[i][m_idx[i]]  = 1'b0;
      if (m_idx[i] == n - 1) m_clr[i] = 1'b0;
      else m_idx[i]++;
    end else begin
      if (we0[i] && a0 != 0) begin m_regs[i][a0] = wd0[i] & dmask(i); m_known[i][a0] = 1'b1; end
      if (we1[i] && a1 != 0) begin m_regs[i][a1] = wd1[i] & dmask(i); m_known[i][a1] = 1'b1; end
      if (we0[i]) m_busy[i][a0] = 1'b0;
      if (we1[i]) m_busy[i][a1] = 1'b0;
      if (iss[i] && ai != 0) m_busy[i][ai] = 1'b1;
      m_busy[i][0] = 1'b0;
      if (creq[i]) begin m_clr[i] = 1'b1; m_idx[i] = 1; end
    end
  endtask

  task automatic push_checks(input int i);
    int nrd = (i == 1) ? 4 : 2;
    for (int p = 0; p < nrd; p++) begin
      int a = int'(ra[i][p]) & (nreg_of(i) - 1);
      logic [63:0] v;
      bit k;
      exp_read(i, a, v, k);
      if (k) q.push_back('{$sformatf("rdata i%0d p%0d a%0d", i, p, a), 0, i, p, v});
      q.push_back('{$sformatf("rbusy i%0d p%0d a%0d", i, p, a), 1, i, p, 64'(m_busy[i][a])});
    end
    q.push_back('{$sformatf("clr_busy i%0d", i), 2, i, 0, 64'(m_clr[i])});
    q.push_back('{$sformatf("clr_done i%0d", i), 3, i, 0,
                  64'(m_clr[i] && m_idx[i] == nreg_of(i) - 1)});
  endtask

  // One clock: record expectations for the current inputs, then advance the model.
  task automatic cyc();
    for (int i = 0; i < 2; i++) push_checks(i);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      we0[i] = 0; we1[i] = 0; iss[i] = 0; creq[i] = 0;
      wa0[i] = '0; wa1[i] = '0; ia[i] = '0; wd0[i] = '0; wd1[i] = '0;
    end
  endtask

  task automatic rand_reads();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 4; p++) ra[i][p] = 5'($urandom_range(0, nreg_of(i) - 1));
  endtask

  task automatic fill(input int i);
    for (int r = 1; r < nreg_of(i); r++) begin
      we0[i] = 1; wa0[i] = 5'(r);
      wd0[i] = (i == 1) ? {32'hC0DE_0000 | 32'(r), 32'(r * 7 + 1)} : 64'(r);
      rand_reads();
      cyc();
    end
    idle_inputs();
  endtask

  always @(negedge clk) begin : monitor
    chk_t e;
    logic [63:0] act;
    while (q.size() != 0) begin
      e = q.pop_front();
      case (e.kind)
        0: act = (e.inst == 1) ? rdata_b[e.port*64 +: 64] : {32'b0, rdata_a[e.port*32 +: 32]};
        1: act = 64'((e.inst == 1) ? rbusy_b[e.port] : rbusy_a[e.port]);
        2: act = 64'(cbusy[e.inst]);
        default: act = 64'(cdone[e.inst]);
      endcase
      chk(e.name, act, e.exp);
    end
  end

  initial begin
    int n0, n1, d0, d1;
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 32; r++) begin m_known[i][r] = 0; m_regs[i][r] = '0; end
    idle_inputs();
    for (int i = 0; i < 2; i++) for (int p = 0; p < 4; p++) ra[i][p] = '0;
    rst_n = 1'b0;
    model_reset();
    #2;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Basic write/read, and write to register 0 ignored.
    we0[0] = 1; wa0[0] = 5; wd0[0] = 64'hDEAD_BEEF; ra[0][0] = 5; cyc();
    idle_inputs(); cyc();
    chk("read5", {32'b0, rdata_a[31:0]}, 64'hDEAD_BEEF);
    we0[0] = 1; wa0[0] = 0; wd0[0] = 64'h1234; ra[0][1] = 0; cyc();
    idle_inputs(); cyc();

    // Same-address write conflict: port 1 wins.
    we0[0] = 1; wa0[0] = 7; wd0[0] = 64'h11;
    we1[0] = 1; wa1[0] = 7; wd1[0] = 64'h22; ra[0][1] = 7; cyc();
    idle_inputs(); cyc();
    chk("conflict7", {32'b0, rdata_a[63:32]}, 64'h22);

    // Scoreboard sequence on register 3, then issue to register 0.
    ra[0][0] = 3;
    iss[0] = 1; ia[0] = 3; cyc(); idle_inputs(); cyc();
    iss[0] = 1; ia[0] = 3; we0[0] = 1; wa0[0] = 3; wd0[0] = 64'h33; cyc(); idle_inputs(); cyc();
    we1[0] = 1; wa1[0] = 3; wd1[0] = 64'h3; cyc(); idle_inputs(); cyc();
    ra[0][0] = 0; iss[0] = 1; ia[0] = 0; cyc(); idle_inputs(); cyc();

    // Full clear on both instances, with a dropped write and issue mid-clear.
    iss[0] = 1; ia[0] = 14; iss[1] = 1; ia[1] = 6; cyc(); idle_inputs();
    fill(0); fill(1);
    for (int r = 0; r < 32; r++) begin
      ra[0][0] = 5'(r); ra[0][1] = 5'(31 - r);
      for (int p = 0; p < 4; p++) ra[1][p] = 5'((r + p * 4) % 16);
      cyc();
    end
    creq[0] = 1; creq[1] = 1; cyc(); idle_inputs();
    n0 = 0; n1 = 0; d0 = 0; d1 = 0;
    for (int k = 0; k < 100 && (cbusy[0] || cbusy[1]); k++) begin
      if (cbusy[0]) n0++;
      if (cbusy[1]) n1++;
      if (cdone[0]) d0++;
      if (cdone[1]) d1++;
      idle_inputs();
      if (k == 4) begin
        we0[0] = 1; wa0[0] = 9; wd0[0] = 64'h99; iss[0] = 1; ia[0] = 12; creq[0] = 1;
      end
      rand_reads();
      cyc();
    end
    idle_inputs();
    chk("clr_cycles_32", 64'(n0), 64'd31);
    chk("clr_cycles_16", 64'(n1), 64'd15);
    chk("clr_done_32", 64'(d0), 64'd1);
    chk("clr_done_16", 64'(d1), 64'd1);
    for (int r = 0; r < 32; r++) begin
      ra[0][0] = 5'(r); ra[0][1] = 5'(r);
      for (int p = 0; p < 4; p++) ra[1][p] = 5'((r + p) % 16);
      cyc();
    end

    // Reset ten cycles into a clear: registers 11.. keep their contents.
    fill(0);
    creq[0] = 1; cyc(); idle_inputs();
    repeat (10) cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy_drop", 64'(cbusy[0]), 64'd0);
    cyc();
    rst_n = 1'b1;
    for (int r = 1; r < 32; r++) begin
      ra[0][0] = 5'(r); #1;
      if (r == 10) chk("abort_reg10", {32'b0, rdata_a[31:0]}, 64'd0);
      if (r == 20) chk("abort_reg20", {32'b0, rdata_a[31:0]}, 64'd20);
      cyc();
    end

    // Randomised traffic on both instances.
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < 2; i++) begin
        we0[i]  = ($urandom_range(0, 2) == 0);
        we1[i]  = ($urandom_range(0, 2) == 0);
        iss[i]  = ($urandom_range(0, 2) == 0);
        creq[i] = ($urandom_range(0, 79) == 0);
        wa0[i]  = 5'($urandom_range(0, nreg_of(i) - 1));
        wa1[i]  = ($urandom_range(0, 3) == 0) ? wa0[i] : 5'($urandom_range(0, nreg_of(i) - 1));
        ia[i]   = ($urandom_range(0, 3) == 0) ? wa0[i] : 5'($urandom_range(0, nreg_of(i) - 1));
        wd0[i]  = {32'($urandom), 32'($urandom)} & dmask(i);
        wd1[i]  = {32'($urandom), 32'($urandom)} & dmask(i);
      end
      rand_reads();
      cyc();
    end
    idle_inputs();
    repeat (2) cyc();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
